// File: rtl/router_out_reader.sv
// Destination-side reader for one router output port.
// Pulls packets from the port FIFO, streams payload, checks parity/address.
module router_out_reader #(
  parameter logic [1:0] PORT_ID    = 2'd0,
  parameter int         READ_DELAY = 0,
  parameter int         CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vld_out,
  input  logic             soft_reset,
  input  logic [7:0]       data_out,
  input  logic             rd_hold,
  output logic             read_enb,
  output logic [7:0]       byte_out,
  output logic             byte_vld,
  output logic             pkt_done,
  output logic [1:0]       pkt_err,
  output logic             pkt_abort,
  output logic [5:0]       pkt_len,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [1:0] {
    IDLE,
    HDR_RD,
    HDR_CAP,
    BODY
  } state_t;

  localparam logic [5:0] DLY = 6'(READ_DELAY);

  state_t     state;
  logic [5:0] dly_cnt;
  logic [1:0] addr;
  logic [7:0] par;
  logic [6:0] remaining;
  logic [6:0] issued;
  logic [6:0] recv;
  logic       rd_q;

  // Read strobe must follow vld_out/rd_hold within the cycle.
  always_comb begin
    read_enb = 1'b0;
    if (!soft_reset) begin
      unique case (state)
        HDR_RD:  read_enb = vld_out & ~rd_hold;
        BODY:    read_enb = vld_out & ~rd_hold
                            & (issued < remaining);
        default: read_enb = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      dly_cnt   <= '0;
      addr      <= '0;
      par       <= '0;
      remaining <= '0;
      issued    <= '0;
      recv      <= '0;
      rd_q      <= 1'b0;
      byte_out  <= '0;
      byte_vld  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= '0;
      pkt_abort <= 1'b0;
      pkt_len   <= '0;
      pkt_count <= '0;
    end else begin
      byte_vld  <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= '0;
      pkt_abort <= 1'b0;
      rd_q      <= read_enb;
      if (soft_reset) begin
        // Any byte still in flight belongs to the flushed packet.
        dly_cnt <= '0;
        rd_q    <= 1'b0;
        if (state != IDLE) begin
          pkt_abort <= 1'b1;
          state     <= IDLE;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (!vld_out) begin
              dly_cnt <= '0;
            end else if (dly_cnt == DLY) begin
              dly_cnt <= '0;
              state   <= HDR_RD;
            end else begin
              dly_cnt <= dly_cnt + 6'd1;
            end
          end
          HDR_RD: begin
            if (read_enb) state <= HDR_CAP;
          end
          HDR_CAP: begin
            pkt_len   <= data_out[7:2];
            addr      <= data_out[1:0];
            par       <= data_out;
            remaining <= {1'b0, data_out[7:2]} + 7'd1;
            issued    <= '0;
            recv      <= '0;
            state     <= BODY;
          end
          BODY: begin
            if (read_enb) issued <= issued + 7'd1;
            if (rd_q) begin
              recv <= recv + 7'd1;
              if (recv == remaining - 7'd1) begin
                pkt_done   <= 1'b1;
                pkt_err[0] <= par != data_out;
                pkt_err[1] <= addr != PORT_ID;
                pkt_count  <= pkt_count + 1'b1;
                state      <= IDLE;
              end else begin
                byte_vld <= 1'b1;
                byte_out <= data_out;
                par      <= par ^ data_out;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
